// File: rtl/ifu_prefetch_queue.sv
// ifu_prefetch_queue
//   Instruction-fetch front end. It issues sequential fetch requests with up to
//   MAX_OUTS requests in flight and buffers the returned instructions, tagged
//   with their PCs, in a DEPTH-entry queue. The EXU drains the queue through a
//   valid/ready port. A redirect flushes the queue and restarts fetch at a new
//   PC. A bus error stops fetching until the next redirect.
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   pc_rtvec                    reset vector, loaded on the first cycle after reset
//   redirect_valid/redirect_pc  flush the queue and restart fetch (bit0 ignored)
//   ifu_req_*                   fetch request channel to the bus
//   ifu_rsp_*                   in-order fetch response channel from the bus
//   ifu_o_*                     queue head towards the EXU, plus the entry count
//   inspect_pc                  next PC to be requested (debug)
module ifu_prefetch_queue #(
    parameter int PC_W     = 32,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_OUTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PC_W-1:0]            pc_rtvec,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       ifu_req_valid,
    input  logic                       ifu_req_ready,
    output logic [PC_W-1:0]            ifu_req_pc,
    input  logic                       ifu_rsp_valid,
    output logic                       ifu_rsp_ready,
    input  logic [INSTR_W-1:0]         ifu_rsp_instr,
    input  logic                       ifu_rsp_err,
    output logic                       ifu_o_valid,
    input  logic                       ifu_o_ready,
    output logic [INSTR_W-1:0]         ifu_o_ir,
    output logic [PC_W-1:0]            ifu_o_pc,
    output logic                       ifu_o_err,
    output logic [$clog2(DEPTH+1)-1:0] ifu_o_count,
    output logic [PC_W-1:0]            inspect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTS + 1);
    localparam logic [PC_W-1:0] PC_MASK = {{(PC_W-1){1'b1}}, 1'b0};
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic [1:0] {BOOT, RUN, ERR_WAIT} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] ir;
        logic [PC_W-1:0]    pc;
        logic               err;
    } entry_t;

    state_t                state, state_nxt;
    entry_t [DEPTH-1:0]    mem;
    logic   [AW-1:0]       rd_ptr, wr_ptr;
    logic   [CW-1:0]       count;
    logic   [OW-1:0]       outs_cnt, drop_cnt, outs_nxt;
    logic   [PC_W-1:0]     fetch_pc, rsp_pc;
    logic   [CW:0]         reserved;
    logic                  flush, req_hsk, rsp_hsk, enq, deq;

    // Redirects only mean something once the fetch PC has been loaded.
    assign flush    = redirect_valid & (state != BOOT);
    // Each outstanding request holds a queue slot, so responses never stall.
    assign reserved = (CW+1)'(outs_cnt) + (CW+1)'(count);

    assign ifu_req_valid = (state == RUN) & ~redirect_valid
                         & (outs_cnt < OW'(MAX_OUTS))
                         & (reserved < (CW+1)'(DEPTH));
    assign ifu_req_pc    = fetch_pc;
    assign ifu_rsp_ready = (state != BOOT);
    assign inspect_pc    = fetch_pc;

    assign req_hsk = ifu_req_valid & ifu_req_ready;
    assign rsp_hsk = ifu_rsp_valid & ifu_rsp_ready;
    // Responses owed from before a redirect are discarded; a response that
    // handshakes in the redirect cycle itself is discarded too.
    assign enq     = rsp_hsk & (drop_cnt == '0) & ~flush;
    assign deq     = ifu_o_valid & ifu_o_ready & ~flush;
    assign outs_nxt = outs_cnt + OW'(req_hsk) - OW'(rsp_hsk);

    assign ifu_o_valid = (count != '0);
    assign ifu_o_ir    = mem[rd_ptr].ir;
    assign ifu_o_pc    = mem[rd_ptr].pc;
    assign ifu_o_err   = mem[rd_ptr].err;
    assign ifu_o_count = count;

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:     state_nxt = RUN;
            RUN:      if (flush) state_nxt = RUN;
                      else if (enq & ifu_rsp_err) state_nxt = ERR_WAIT;
            ERR_WAIT: if (flush) state_nxt = RUN;
            default:  state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            fetch_pc <= '0;
            rsp_pc   <= '0;
            outs_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            outs_cnt <= outs_nxt;
            if (state == BOOT) begin
                fetch_pc <= pc_rtvec & PC_MASK;
                rsp_pc   <= pc_rtvec & PC_MASK;
            end else if (flush) begin
                fetch_pc <= redirect_pc & PC_MASK;
                rsp_pc   <= redirect_pc & PC_MASK;
                // No request is issued in a redirect cycle, so every response
                // still owed after this edge belongs to the old stream.
                drop_cnt <= outs_nxt;
            end else begin
                if (req_hsk) fetch_pc <= fetch_pc + PC_STEP;
                if (enq)     rsp_pc   <= rsp_pc + PC_STEP;
                if (rsp_hsk && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= '{ir: ifu_rsp_instr, pc: rsp_pc, err: ifu_rsp_err};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    a_no_stray_rsp : assert property (@(posedge clk) disable iff (!rst)
        !(ifu_rsp_valid && outs_cnt == '0));
    a_space : assert property (@(posedge clk) disable iff (!rst)
        (32'(count) + 32'(outs_cnt) - 32'(drop_cnt)) <= DEPTH);
endmodule
